// File: rtl/avalon_sram_agent_pkg.sv
// Shared types for the Avalon-MM SRAM agent: data word, FSM states, access size decode.
package avalon_sram_agent_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned CNT_W  = 4;

  typedef logic [WORD_W-1:0] word;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} agent_state_t;

  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_BAD} access_size_t;

  // Request as latched at accept; the bus is not looked at again until the next IDLE
  typedef struct packed {
    logic            is_read;
    logic            is_write;
    word             addr;
    logic [BE_W-1:0] be;
    word             data;
  } req_t;

  // Host data is always low-lane aligned, so only these three patterns are legal
  function automatic access_size_t be_to_size(input bit [3:0] be);
    unique case (be)
      4'b0001: return SZ_BYTE;
      4'b0011: return SZ_HALF;
      4'b1111: return SZ_WORD;
      default: return SZ_BAD;
    endcase
  endfunction

endpackage

// File: rtl/avalon_sram_agent_byte_lane_ram.sv
// Single-port word RAM with per-byte write enables and a registered read port.
module byte_lane_ram
  import avalon_sram_agent_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic                           i_en,
  input  logic [BE_W-1:0]                i_we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] i_addr,
  input  word                            i_wdata,
  output word                            o_rdata
);

  word r_mem [DEPTH_WORDS];
  word r_rdata;

  // Byte-lane write, or a read that holds its result until the next read
  always_ff @(posedge clk) begin
    if (i_en) begin
      for (int b = 0; b < int'(BE_W); b++) begin
        if (i_we[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
      if (i_we == '0) r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/avalon_sram_agent.sv
// Avalon-MM agent in front of an on-chip SRAM: fixed wait states, lane alignment, sticky fault.
module avalon_sram_agent
  import avalon_sram_agent_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_read,
  input  logic            i_write,
  input  logic [31:0]     i_address,
  input  logic [BE_W-1:0] i_byteenable,
  input  word             i_host_to_agent,
  output word             o_agent_to_host_c,
  output logic            o_waitrequest_c,
  output logic            o_readdatavalid,
  output logic            o_fault,
  output word             o_fault_addr,
  input  logic            i_fault_clear
);

  localparam int unsigned AW       = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN     = 32'(DEPTH_WORDS * 4);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_STATES - 1);

  agent_state_t     r_state, w_state_nxt;
  req_t             r_req;
  logic             r_bad;
  logic [AW-1:0]    r_idx;
  logic [CNT_W-1:0] r_cnt;

  logic             w_accept, w_rvalid_nxt, w_bad_in, w_commit;
  word              w_off_in, w_rd_mask, w_ram_wdata, w_ram_rdata;
  access_size_t     w_size_in;
  logic             w_ram_en;
  logic [BE_W-1:0]  w_ram_we;
  logic [AW-1:0]    w_ram_addr;

  // Decode legality of the request currently on the bus
  assign w_off_in  = i_address - BASE_ADDR;
  assign w_size_in = be_to_size(i_byteenable);

  always_comb begin
    w_bad_in = 1'b0;
    if (i_read && i_write)                               w_bad_in = 1'b1;
    if (w_off_in >= SPAN)                                w_bad_in = 1'b1;
    if (w_size_in == SZ_BAD)                             w_bad_in = 1'b1;
    if (w_size_in == SZ_HALF && i_address[1:0] == 2'd3)  w_bad_in = 1'b1;
    if (w_size_in == SZ_WORD && i_address[1:0] != 2'd0)  w_bad_in = 1'b1;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state; readdatavalid is precomputed so it is registered into RESP
  always_comb begin
    w_state_nxt  = r_state;
    w_accept     = 1'b0;
    w_rvalid_nxt = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_read || i_write) begin
          w_accept = 1'b1;
          if (WAIT_STATES == 1) begin
            w_state_nxt  = RESP;
            w_rvalid_nxt = i_read;
          end else begin
            w_state_nxt  = WAIT;
          end
        end
      end
      WAIT: begin
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt  = RESP;
          w_rvalid_nxt = r_req.is_read;
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Request latch, wait counter and readdatavalid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req           <= '0;
      r_bad           <= 1'b0;
      r_idx           <= '0;
      r_cnt           <= '0;
      o_readdatavalid <= 1'b0;
    end else begin
      o_readdatavalid <= w_rvalid_nxt;
      if (w_accept) begin
        r_req <= '{is_read: i_read, is_write: i_write, addr: i_address,
                   be: i_byteenable, data: i_host_to_agent};
        r_bad <= w_bad_in;
        r_idx <= w_off_in[AW+1:2];
        r_cnt <= CNT_INIT;
      end else if (r_state == WAIT) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

  // Sticky fault; a fault landing with a clear wins and records its own address
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_fault      <= 1'b0;
      o_fault_addr <= '0;
    end else if (r_state == RESP && r_bad) begin
      o_fault <= 1'b1;
      if (!o_fault || i_fault_clear) o_fault_addr <= r_req.addr;
    end else if (i_fault_clear) begin
      o_fault      <= 1'b0;
      o_fault_addr <= '0;
    end
  end

  // RAM port: read issued at accept, write committed in RESP unless reset is asserted
  assign w_commit    = (r_state == RESP) && r_req.is_write && !r_bad && !rst;
  assign w_ram_en    = ((r_state == IDLE) && i_read) || w_commit;
  assign w_ram_we    = w_commit ? BE_W'(r_req.be << r_req.addr[1:0]) : '0;
  assign w_ram_addr  = (r_state == IDLE) ? w_off_in[AW+1:2] : r_idx;
  assign w_ram_wdata = word'(r_req.data << {r_req.addr[1:0], 3'b000});

  byte_lane_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .clk     (clk),
    .i_en    (w_ram_en),
    .i_we    (w_ram_we),
    .i_addr  (w_ram_addr),
    .i_wdata (w_ram_wdata),
    .o_rdata (w_ram_rdata)
  );

  // Read path: shift addressed lanes down and zero everything above the access size
  always_comb begin
    w_rd_mask = '0;
    for (int b = 0; b < int'(BE_W); b++) w_rd_mask[8*b +: 8] = {8{r_req.be[b]}};
  end

  assign o_agent_to_host_c = (r_state == RESP && r_req.is_read && !r_bad)
                             ? ((w_ram_rdata >> {r_req.addr[1:0], 3'b000}) & w_rd_mask)
                             : '0;
  assign o_waitrequest_c   = (r_state != RESP);

endmodule
